// File: rtl/ddr3_test_sequencer.sv
// Write-then-read sweep of the whole DDR3 word space through an Avalon-MM style port.
// Reads are throttled by a count of commands still waiting for their data.
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// S_WAIT_FOR_INIT | waiting for controller init and the calibration verdict
// S_WRITE         | writing pattern ^ index to every word, index 0..last
// S_READ          | issuing reads 0..last, limited by the outstanding count
// S_DRAIN         | all reads issued, waiting for the remaining read data
// S_DONE          | terminal: every read word returned, reads_complete held
// S_ERROR         | terminal: calibration failed, cal_error held
module ddr3_test_sequencer #(
  parameter int ADDR_WIDTH      = 24,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  output logic                  avl_burstbegin,
  output logic                  avl_read_req,
  output logic                  avl_write_req,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [63:0]           avl_wdata,
  output logic [7:0]            avl_be,
  output logic [2:0]            avl_size,
  output logic                  busy,
  output logic                  reads_complete,
  output logic                  cal_error
);

  localparam int                  OW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]       MAX_CNT  = OW'(MAX_OUTSTANDING);
  localparam logic [63:0]         PATTERN  = 64'hdeadfadebabebeef;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_WAIT_FOR_INIT,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [OW-1:0]         r_outstanding;
  logic                  r_read_req;
  logic                  r_write_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_wdata;
  logic                  r_busy;
  logic                  r_reads_complete;
  logic                  r_cal_error;

  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_rd_return;
  logic [OW-1:0]         w_outstanding_nxt;
  logic [ADDR_WIDTH-1:0] w_index_inc;
  logic                  w_room;

  function automatic logic [63:0] wdata_for(input logic [ADDR_WIDTH-1:0] idx);
    logic [63:0] v;
    v = '0;
    v[ADDR_WIDTH-1:0] = idx;
    return PATTERN ^ v;
  endfunction

  assign w_wr_accept = r_write_req & avl_ready;
  assign w_rd_accept = r_read_req & avl_ready;
  // A return with nothing outstanding is a stray pulse and must not underflow.
  assign w_rd_return = avl_rdata_valid && (r_outstanding != '0) &&
                       ((r_state == S_READ) || (r_state == S_DRAIN));
  assign w_index_inc = r_index + 1'b1;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_rd_accept && !w_rd_return) begin
      w_outstanding_nxt = r_outstanding + OW'(1);
    end else if (w_rd_return && !w_rd_accept) begin
      w_outstanding_nxt = r_outstanding - OW'(1);
    end
  end

  // Next-cycle request permission comes from the counter as it will be registered,
  // so a request is never presented against a full window.
  assign w_room = (w_outstanding_nxt < MAX_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_WAIT_FOR_INIT;
      r_index          <= '0;
      r_outstanding    <= '0;
      r_read_req       <= 1'b0;
      r_write_req      <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_busy           <= 1'b0;
      r_reads_complete <= 1'b0;
      r_cal_error      <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_FOR_INIT: begin
          if (ddr3_init_done) begin
            if (ddr3_cal_success) begin
              r_state     <= S_WRITE;
              r_index     <= '0;
              r_addr      <= '0;
              r_wdata     <= wdata_for('0);
              r_write_req <= 1'b1;
              r_busy      <= 1'b1;
            end else if (ddr3_cal_fail) begin
              r_state     <= S_ERROR;
              r_cal_error <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (w_wr_accept) begin
            if (r_index == LAST_IDX) begin
              r_state     <= S_READ;
              r_index     <= '0;
              r_addr      <= '0;
              r_write_req <= 1'b0;
            end else begin
              r_index <= w_index_inc;
              r_addr  <= w_index_inc;
              r_wdata <= wdata_for(w_index_inc);
            end
          end
        end

        S_READ: begin
          r_outstanding <= w_outstanding_nxt;
          if (w_rd_accept && (r_index == LAST_IDX)) begin
            r_state    <= S_DRAIN;
            r_index    <= '0;
            r_read_req <= 1'b0;
          end else begin
            if (w_rd_accept) begin
              r_index <= w_index_inc;
              r_addr  <= w_index_inc;
            end
            r_read_req <= w_room;
          end
        end

        S_DRAIN: begin
          r_outstanding <= w_outstanding_nxt;
          if (r_outstanding == '0) begin
            r_state          <= S_DONE;
            r_busy           <= 1'b0;
            r_reads_complete <= 1'b1;
          end
        end

        S_DONE, S_ERROR: begin
          r_state <= r_state;
        end

        default: begin
          r_state     <= S_WAIT_FOR_INIT;
          r_read_req  <= 1'b0;
          r_write_req <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign avl_burstbegin = r_read_req | r_write_req;
  assign avl_read_req   = r_read_req;
  assign avl_write_req  = r_write_req;
  assign avl_addr       = r_addr;
  assign avl_wdata      = r_wdata;
  assign avl_be         = 8'hff;
  assign avl_size       = 3'h1;
  assign busy           = r_busy;
  assign reads_complete = r_reads_complete;
  assign cal_error      = r_cal_error;

endmodule

// File: tb/tb_ddr3_test_sequencer.sv
// Bench for ddr3_test_sequencer with an 8-word space and a 3-deep read window.
// A transaction-level model tracks words written, words read and reads in flight.
module tb_ddr3_test_sequencer;

  localparam int AW   = 3;
  localparam int N    = 8;
  localparam int MAXO = 3;

  logic        clk;
  logic        reset_n;
  logic        init_done, cal_success, cal_fail, ready, rv;
  logic        bb, rr, wr, busy, rc, cerr;
  logic [AW-1:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [2:0]  size;

  int n_checks = 0;
  int n_pass   = 0;

  ddr3_test_sequencer #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ddr3_init_done(init_done), .ddr3_cal_success(cal_success), .ddr3_cal_fail(cal_fail),
    .avl_ready(ready), .avl_rdata_valid(rv),
    .avl_burstbegin(bb), .avl_read_req(rr), .avl_write_req(wr),
    .avl_addr(addr), .avl_wdata(wdata), .avl_be(be), .avl_size(size),
    .busy(busy), .reads_complete(rc), .cal_error(cerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_wdata(input int i);
    return 64'hdeadfadebabebeef ^ 64'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; init_done = 1'b0; cal_success = 1'b0; cal_fail = 1'b0;
    ready = 1'b0; rv = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; init_done = 1'b0; cal_success = 1'b0; cal_fail = 1'b0;
    ready = 1'b1; rv = 1'b1;
    #1;
    n_checks++; if ({bb, rr, wr, addr, wdata, busy, rc, cerr} !== '0) $display("FAIL reset_outputs got=%0h required=0", {bb, rr, wr, addr, wdata, busy, rc, cerr}); else n_pass++;
    n_checks++; if (be !== 8'hff) $display("FAIL byte_enable got=%0h required=ff", be); else n_pass++;
    n_checks++; if (size !== 3'h1) $display("FAIL burst_size got=%0h required=1", size); else n_pass++;
    repeat (2) step();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ready = 1'($urandom_range(1)); rv = 1'($urandom_range(1));
      init_done = (c >= 5);
      step();
      n_checks++; if ({rr, wr, busy, cerr, rc} !== 5'b0) $display("FAIL wait_idle got=%0b required=0", {rr, wr, busy, cerr, rc}); else n_pass++;
    end
  endtask

  task automatic run_sequence(input int rpct, input int vpct, output int wr_span);
    int wr_n, rd_n, outs, drain, cyc, first_wr, last_wr;
    bit p_pend, exp_rc, exp_busy;
    logic p_rr, p_wr;
    logic [AW-1:0] p_addr;
    logic [63:0] p_wd;
    wr_n = 0; rd_n = 0; outs = 0; drain = 0; cyc = 0; first_wr = -1; last_wr = -1;
    p_pend = 0; p_rr = 0; p_wr = 0; p_addr = '0; p_wd = '0;
    do_reset();
    repeat (5) step();
    init_done = 1'b1; cal_success = 1'b1;
    while (drain < 2 && cyc < 3000) begin
      step();
      cyc++;
      n_checks++; if (bb !== (rr | wr)) $display("FAIL burstbegin got=%0b required=%0b", bb, rr | wr); else n_pass++;
      n_checks++; if ((rr & wr) !== 1'b0) $display("FAIL req_exclusive got=%0b%0b required=one-hot", rr, wr); else n_pass++;
      if (p_pend) begin
        n_checks++; if ({rr, wr, addr, wdata} !== {p_rr, p_wr, p_addr, p_wd}) $display("FAIL cmd_hold got=%0h required=%0h", {rr, wr, addr, wdata}, {p_rr, p_wr, p_addr, p_wd}); else n_pass++;
      end
      if (wr) begin
        if (first_wr < 0) first_wr = cyc;
        n_checks++; if (wr_n >= N || addr !== AW'(wr_n) || wdata !== exp_wdata(wr_n)) $display("FAIL write_cmd got=%0h/%0h required=%0h/%0h", addr, wdata, wr_n, exp_wdata(wr_n)); else n_pass++;
      end
      if (rr) begin
        n_checks++; if (wr_n < N || rd_n >= N || addr !== AW'(rd_n) || outs >= MAXO) $display("FAIL read_cmd got=addr %0h required=addr %0h (written %0d, in flight %0d)", addr, rd_n, wr_n, outs); else n_pass++;
      end
      exp_rc = (rd_n == N) && (outs == 0) && (drain > 0);
      if (rd_n == N && outs == 0) drain++;
      n_checks++; if (rc !== exp_rc) $display("FAIL reads_complete got=%0b required=%0b", rc, exp_rc); else n_pass++;
      exp_busy = (first_wr >= 0) && !exp_rc;
      n_checks++; if (busy !== exp_busy) $display("FAIL busy got=%0b required=%0b", busy, exp_busy); else n_pass++;
      ready = ($urandom_range(99) < rpct);
      if (outs > 0) rv = ($urandom_range(99) < vpct);
      else rv = ($urandom_range(99) < vpct / 4);
      if (wr && ready) begin wr_n++; last_wr = cyc; end
      if (rr && ready) begin rd_n++; outs++; end
      if (rv && outs > 0 && !(rr && ready && outs == 1 && 0)) begin end
      p_pend = (rr | wr) && !ready;
      p_rr = rr; p_wr = wr; p_addr = addr; p_wd = wdata;
      // Returns count against what was in flight before this cycle's acceptance.
      if (rv && (outs - ((rr && ready) ? 1 : 0)) > 0) outs--;
    end
    n_checks++; if (drain < 2) $display("FAIL sequence_timeout got=%0d cycles required=completion", cyc); else n_pass++;
    wr_span = last_wr - first_wr + 1;
    ready = 1'b0; rv = 1'b0;
  endtask

  task automatic test_basic();
    int span;
    run_sequence(100, 100, span);
    n_checks++; if (span !== N) $display("FAIL write_burst_span got=%0d required=%0d", span, N); else n_pass++;
  endtask

  task automatic test_random();
    int span;
    run_sequence(70, 50, span);
    run_sequence(40, 80, span);
    run_sequence(90, 15, span);
  endtask

  task automatic test_cal_fail();
    do_reset();
    step();
    init_done = 1'b1; cal_fail = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ready = 1'($urandom_range(1)); rv = 1'($urandom_range(1));
      step();
      n_checks++; if ({rr, wr, busy, cerr} !== 4'b0001) $display("FAIL cal_fail_state got=%0b required=0001", {rr, wr, busy, cerr}); else n_pass++;
    end
    cal_fail = 1'b0; cal_success = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++; if ({rr, wr, busy, rc, cerr} !== 5'b00001) $display("FAIL error_terminal got=%0b required=00001", {rr, wr, busy, rc, cerr}); else n_pass++;
    end
  endtask

  task automatic test_cal_both();
    do_reset();
    init_done = 1'b1; cal_success = 1'b1; cal_fail = 1'b1;
    step();
    n_checks++; if ({wr, cerr, addr} !== {1'b1, 1'b0, 3'd0}) $display("FAIL success_wins got=%0b%0b/%0h required=10/0", wr, cerr, addr); else n_pass++;
  endtask

  task automatic test_backpressure();
    int held, acc2;
    bit seen3;
    held = 0; acc2 = 0; seen3 = 0;
    do_reset();
    init_done = 1'b1; cal_success = 1'b1; ready = 1'b1;
    for (int c = 0; c < 40 && !seen3; c++) begin
      step();
      if (wr && addr == 3'd2) begin
        n_checks++; if (wdata !== 64'hdeadfadebabebeed) $display("FAIL stalled_wdata got=%0h required=deadfadebabebeed", wdata); else n_pass++;
        ready = (held >= 3);
        held++;
        if (ready) acc2++;
      end else begin
        ready = 1'b1;
        if (wr && addr == 3'd3) seen3 = 1;
      end
    end
    n_checks++; if (held !== 4) $display("FAIL stall_cycles got=%0d required=4", held); else n_pass++;
    n_checks++; if (acc2 !== 1) $display("FAIL stall_acceptances got=%0d required=1", acc2); else n_pass++;
    n_checks++; if (seen3 !== 1'b1) $display("FAIL after_stall got=%0b required=1", seen3); else n_pass++;
  endtask

  task automatic test_limit();
    int wr_acc, rd_acc;
    wr_acc = 0; rd_acc = 0;
    do_reset();
    init_done = 1'b1; cal_success = 1'b1; ready = 1'b1;
    for (int c = 0; c < 60 && wr_acc < N; c++) begin
      step();
      if (wr) wr_acc++;
    end
    for (int c = 0; c < 20; c++) begin
      step();
      rv = (rd_acc == 0);
      if (rr) rd_acc++;
    end
    n_checks++; if (rd_acc !== MAXO) $display("FAIL window_fill got=%0d required=%0d", rd_acc, MAXO); else n_pass++;
    n_checks++; if (rr !== 1'b0) $display("FAIL window_block got=%0b required=0", rr); else n_pass++;
    rv = 1'b1;
    step();
    n_checks++; if ({rr, addr} !== {1'b1, 3'(MAXO)}) $display("FAIL window_reopen got=%0b/%0h required=1/%0h", rr, addr, MAXO); else n_pass++;
    step();
    n_checks++; if ({rr, addr} !== {1'b1, 3'(MAXO + 1)}) $display("FAIL accept_with_return got=%0b/%0h required=1/%0h", rr, addr, MAXO + 1); else n_pass++;
    rv = 1'b0;
    step();
    n_checks++; if (rr !== 1'b0) $display("FAIL window_refull got=%0b required=0", rr); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit hit;
    hit = 0;
    do_reset();
    init_done = 1'b1; cal_success = 1'b1; ready = 1'b1; rv = 1'b1;
    for (int c = 0; c < 80 && !hit; c++) begin
      step();
      if (rr && addr == 3'd4) hit = 1;
    end
    n_checks++; if (hit !== 1'b1) $display("FAIL reach_read4 got=%0b required=1", hit); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({bb, rr, wr, addr, wdata, busy, rc, cerr} !== '0) $display("FAIL async_reset got=%0h required=0", {bb, rr, wr, addr, wdata, busy, rc, cerr}); else n_pass++;
    rv = 1'b0; init_done = 1'b0; cal_success = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    n_checks++; if ({rr, wr, busy} !== 3'b0) $display("FAIL restart_wait got=%0b required=0", {rr, wr, busy}); else n_pass++;
    init_done = 1'b1; cal_success = 1'b1;
    step();
    n_checks++; if ({wr, addr, wdata} !== {1'b1, 3'd0, 64'hdeadfadebabebeef}) $display("FAIL restart_write got=%0b/%0h/%0h required=1/0/deadfadebabebeef", wr, addr, wdata); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0; init_done = 1'b0; cal_success = 1'b0; cal_fail = 1'b0;
    ready = 1'b0; rv = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_cal_fail();
    test_cal_both();
    test_backpressure();
    test_limit();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
